// File: rtl/lsu_controller_if.sv
// CPU-side request/response channel of the load/store sequencer.
// The master issues one request at a time and waits for the completion pulse.
interface lsu_controller_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_ldst;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_ldst, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_ldst, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_controller.sv
// Load/store sequencer: alignment/MMIO decode, BRAM read-modify-write for
// sub-word stores, lane extraction with sign/zero extension for loads.
module lsu_controller #(
  parameter int          ADDR_W    = 14,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic              clk,
  input  logic              rst,
  lsu_controller_if.slave   bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              io_re,
  output logic              io_we,
  output logic [7:0]        io_addr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata
);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  localparam logic [7:0] LOAD_LAST  = 8'(RD_LAT - 1);
  localparam logic [7:0] STORE_LAST = (RD_LAT >= 2) ? 8'(RD_LAT - 2) : 8'd0;

  typedef enum logic [2:0] {IDLE, ERR, ISSUE, WAIT, MERGE, IO, RESP} state_t;

  state_t      state_r;
  logic [2:0]  op_r;
  logic [1:0]  lane_r;
  logic [15:0] wdata_r;
  logic [7:0]  wait_cnt_r;
  logic [31:0] mem_wdata_r;
  logic        resp_valid_r;
  logic        resp_err_r;
  logic [31:0] resp_rdata_r;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic state_t decode(input logic [2:0] op, input logic [31:0] addr);
    logic   mis;
    logic   mmio;
    state_t nxt;
    mis  = (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && addr[0]) ||
           (((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'd0));
    mmio = (addr >= MMIO_BASE);
    if (mis)                                      nxt = ERR;
    else if (mmio && ((op == OP_SB) || (op == OP_SH))) nxt = ERR;
    else if (mmio)                                nxt = IO;
    else                                          nxt = ISSUE;
    return nxt;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[8*lane +: 8];
    h = word[16*lane[1] +: 16];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LBU:  r = {24'd0, b};
      OP_LHU:  r = {16'd0, h};
      OP_LW:   r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] op, input logic [1:0] lane,
                                              input logic [31:0] word, input logic [15:0] wd);
    logic [31:0] m;
    m = word;
    if (op == OP_SB) m[8*lane +: 8]       = wd[7:0];
    else             m[16*lane[1] +: 16]  = wd;
    return m;
  endfunction

  assign bus.req_ready  = (state_r == IDLE) && !rst;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.resp_rdata = resp_rdata_r;
  // The merge word is formed from the read data in the very cycle it arrives.
  assign mem_wdata = (state_r == MERGE) ? store_merge(op_r, lane_r, mem_rdata, wdata_r)
                                        : mem_wdata_r;

  // Sequencer FSM with all strobes and response fields registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      op_r         <= 3'd0;
      lane_r       <= 2'd0;
      wdata_r      <= 16'd0;
      wait_cnt_r   <= 8'd0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata_r  <= 32'd0;
      io_re        <= 1'b0;
      io_we        <= 1'b0;
      io_addr      <= 8'd0;
      io_wdata     <= 32'd0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'd0;
    end else begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      io_re        <= 1'b0;
      io_we        <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'd0;
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            op_r    <= bus.req_ldst;
            lane_r  <= bus.req_addr[1:0];
            wdata_r <= bus.req_wdata[15:0];
            case (decode(bus.req_ldst, bus.req_addr))
              ERR: begin
                state_r      <= ERR;
                resp_valid_r <= 1'b1;
                resp_err_r   <= 1'b1;
              end
              IO: begin
                state_r  <= IO;
                io_re    <= !is_store(bus.req_ldst);
                io_we    <= is_store(bus.req_ldst);
                io_addr  <= bus.req_addr[7:0];
                io_wdata <= bus.req_wdata;
              end
              default: begin
                state_r     <= ISSUE;
                mem_en      <= 1'b1;
                mem_we      <= (bus.req_ldst == OP_SW);
                mem_addr    <= bus.req_addr[ADDR_W+1:2];
                mem_wdata_r <= (bus.req_ldst == OP_SW) ? bus.req_wdata : 32'd0;
              end
            endcase
          end else begin
            state_r <= IDLE;
          end
        end
        ERR: state_r <= IDLE;
        IO: begin
          state_r      <= RESP;
          resp_valid_r <= 1'b1;
          resp_rdata_r <= is_store(op_r) ? 32'd0 : load_extract(op_r, lane_r, io_rdata);
        end
        ISSUE: begin
          wait_cnt_r <= 8'd0;
          if (op_r == OP_SW) begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
          end else if (is_store(op_r) && (RD_LAT == 1)) begin
            state_r <= MERGE;
            mem_en  <= 1'b1;
            mem_we  <= 1'b1;
          end else begin
            state_r <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt_r <= wait_cnt_r + 8'd1;
          if (!is_store(op_r) && (wait_cnt_r == LOAD_LAST)) begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_rdata_r <= load_extract(op_r, lane_r, mem_rdata);
          end else if (is_store(op_r) && (wait_cnt_r == STORE_LAST)) begin
            state_r <= MERGE;
            mem_en  <= 1'b1;
            mem_we  <= 1'b1;
          end else begin
            state_r <= WAIT;
          end
        end
        MERGE: begin
          state_r      <= RESP;
          resp_valid_r <= 1'b1;
        end
        RESP:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench: table of single transactions against a BRAM/MMIO model,
// plus a reset-during-read-modify-write sequence.
module tb_lsu_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en, mem_we, io_re, io_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, io_wdata;
  logic [31:0] io_rdata = 32'd0;
  logic [7:0]  io_addr;
  logic [31:0] ram [0:16383];
  logic [31:0] rd_q = 32'd0;

  int n_cmp = 0;
  int n_fail = 0;
  int en_cnt = 0, we_cnt = 0, io_cnt = 0, rv_cnt = 0;
  logic [31:0] last_waddr = 32'd0, last_wdata = 32'd0;

  lsu_controller_if bus();

  lsu_controller #(.ADDR_W(14), .RD_LAT(1), .MMIO_BASE(32'hFFFF_FF00)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .io_re(io_re), .io_we(io_we), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous BRAM model, one cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        rd_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = rd_q;

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_en) en_cnt++;
    if (mem_we) begin we_cnt++; last_waddr = {18'd0, mem_addr}; last_wdata = mem_wdata; end
    if (io_re || io_we) io_cnt++;
    if (io_we) begin last_waddr = {24'd0, io_addr}; last_wdata = io_wdata; end
    if (bus.resp_valid) rv_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  ldst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] io_rd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_en;
    int          exp_we;
    int          exp_io;
    logic [31:0] exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic do_req(input vec_t v, input int idx);
    int lat;
    bit got;
    int en0, we0, io0;
    logic [31:0] rdata;
    logic err;
    string tag;
    tag = $sformatf("v%0d", idx);
    lat = 0; got = 1'b0; rdata = 32'd0; err = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_idle"}, {31'd0, bus.req_ready}, 32'd1);
    en0 = en_cnt; we0 = we_cnt; io0 = io_cnt;
    bus.req_valid = 1'b1; bus.req_ldst = v.ldst; bus.req_addr = v.addr;
    bus.req_wdata = v.wdata; io_rdata = v.io_rd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_addr = 32'hDEAD_BEEF; bus.req_wdata = 32'h0BAD_F00D;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        got = 1'b1; lat = i; rdata = bus.resp_rdata; err = bus.resp_err;
      end
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: got no resp_valid expected one within 10 cycles", tag);
    end else begin
      chk({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
      chk({tag, "_rdata"}, rdata, v.exp_rdata);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
      @(negedge clk);
      chk({tag, "_pulse"}, {31'd0, bus.resp_valid}, 32'd0);
      chk({tag, "_en_cnt"}, 32'(en_cnt - en0), 32'(v.exp_en));
      chk({tag, "_we_cnt"}, 32'(we_cnt - we0), 32'(v.exp_we));
      chk({tag, "_io_cnt"}, 32'(io_cnt - io0), 32'(v.exp_io));
      if (v.exp_we != 0 || v.ldst == 3'd7) begin
        chk({tag, "_waddr"}, last_waddr, v.exp_waddr);
        chk({tag, "_wdata"}, last_wdata, v.exp_wdata);
      end
    end
  endtask

  vec_t vt [$];

  initial begin
    int rv0, we0;
    for (int i = 0; i < 16384; i++) ram[i] = 32'd0;
    bus.req_valid = 1'b0; bus.req_ldst = 3'd0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;

    // ldst addr wdata io_rd | rdata err lat en we io waddr wdata
    vt.push_back('{3'd7, 32'd100, 32'h1234_56F8, 32'd0, 32'd0, 1'b0, 2, 1, 1, 0, 32'd25, 32'h1234_56F8});
    vt.push_back('{3'd1, 32'd102, 32'd0, 32'd0, 32'h0000_1234, 1'b0, 3, 1, 0, 0, 32'd0, 32'd0});
    vt.push_back('{3'd0, 32'd100, 32'd0, 32'd0, 32'hFFFF_FFF8, 1'b0, 3, 1, 0, 0, 32'd0, 32'd0});
    vt.push_back('{3'd3, 32'd100, 32'd0, 32'd0, 32'h0000_00F8, 1'b0, 3, 1, 0, 0, 32'd0, 32'd0});
    vt.push_back('{3'd5, 32'd101, 32'hFFFF_FFAB, 32'd0, 32'd0, 1'b0, 3, 2, 1, 0, 32'd25, 32'h1234_ABF8});
    vt.push_back('{3'd2, 32'd100, 32'd0, 32'd0, 32'h1234_ABF8, 1'b0, 3, 1, 0, 0, 32'd0, 32'd0});
    vt.push_back('{3'd6, 32'd102, 32'hFFFF_DE98, 32'd0, 32'd0, 1'b0, 3, 2, 1, 0, 32'd25, 32'hDE98_ABF8});
    vt.push_back('{3'd2, 32'd100, 32'd0, 32'd0, 32'hDE98_ABF8, 1'b0, 3, 1, 0, 0, 32'd0, 32'd0});
    vt.push_back('{3'd4, 32'd102, 32'd0, 32'd0, 32'h0000_DE98, 1'b0, 3, 1, 0, 0, 32'd0, 32'd0});
    vt.push_back('{3'd1, 32'd102, 32'd0, 32'd0, 32'hFFFF_DE98, 1'b0, 3, 1, 0, 0, 32'd0, 32'd0});
    vt.push_back('{3'd4, 32'd100, 32'd0, 32'd0, 32'h0000_ABF8, 1'b0, 3, 1, 0, 0, 32'd0, 32'd0});
    vt.push_back('{3'd7, 32'hFFFF_FF04, 32'd5, 32'd0, 32'd0, 1'b0, 2, 0, 0, 1, 32'h04, 32'd5});
    vt.push_back('{3'd2, 32'hFFFF_FF00, 32'd0, 32'hA5, 32'hA5, 1'b0, 2, 0, 0, 1, 32'd0, 32'd0});
    vt.push_back('{3'd0, 32'hFFFF_FF03, 32'd0, 32'h80FF_0000, 32'hFFFF_FF80, 1'b0, 2, 0, 0, 1, 32'd0, 32'd0});
    vt.push_back('{3'd1, 32'd101, 32'd0, 32'd0, 32'd0, 1'b1, 1, 0, 0, 0, 32'd0, 32'd0});
    vt.push_back('{3'd2, 32'd102, 32'd0, 32'd0, 32'd0, 1'b1, 1, 0, 0, 0, 32'd0, 32'd0});
    vt.push_back('{3'd5, 32'hFFFF_FF00, 32'd7, 32'd0, 32'd0, 1'b1, 1, 0, 0, 0, 32'd0, 32'd0});
    vt.push_back('{3'd6, 32'hFFFF_FF02, 32'd7, 32'd0, 32'd0, 1'b1, 1, 0, 0, 0, 32'd0, 32'd0});
    vt.push_back('{3'd5, 32'd103, 32'h0000_0011, 32'd0, 32'd0, 1'b0, 3, 2, 1, 0, 32'd25, 32'h1198_ABF8});
    vt.push_back('{3'd2, 32'h0001_0064, 32'd0, 32'd0, 32'h1198_ABF8, 1'b0, 3, 1, 0, 0, 32'd0, 32'd0});

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

    for (int i = 0; i < vt.size(); i++) do_req(vt[i], i);

    // Reset asserted in the cycle after an SB is accepted.
    @(negedge clk);
    rv0 = rv_cnt; we0 = we_cnt;
    bus.req_valid = 1'b1; bus.req_ldst = 3'd5; bus.req_addr = 32'd100; bus.req_wdata = 32'h0000_0077;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready_after", {31'd0, bus.req_ready}, 32'd1);
    chk("mid_rst_no_we", 32'(we_cnt - we0), 32'd0);
    chk("mid_rst_no_resp", 32'(rv_cnt - rv0), 32'd0);
    do_req('{3'd2, 32'd100, 32'd0, 32'd0, 32'h1198_ABF8, 1'b0, 3, 1, 0, 0, 32'd0, 32'd0}, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
